// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
// Shares the single register-file write port between the ALU writeback pipe
// and the variable-latency load unit. It uses round-robin arbitration with a
// registered write stage. A per-register pending scoreboard drives the decode
// RAW stall and the WAW issue block.
module regfile_write_scheduler #(
  parameter  int WORD_SIZE      = 32,
  parameter  int REGISTER_COUNT = 32,
  localparam int AW             = $clog2(REGISTER_COUNT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rdAdr,
  output logic                 issue_ready,
  input  logic [AW-1:0]        rs1Adr,
  input  logic [AW-1:0]        rs2Adr,
  output logic                 Stall,
  input  logic                 alu_valid,
  input  logic [AW-1:0]        alu_rdAdr,
  input  logic [WORD_SIZE-1:0] alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [AW-1:0]        mem_rdAdr,
  input  logic [WORD_SIZE-1:0] mem_data,
  output logic                 mem_ready,
  output logic                 WriteEnable,
  output logic [AW-1:0]        rd1Adr,
  output logic [WORD_SIZE-1:0] Rd1
);

  // Identity of the requester granted most recently (round-robin pointer).
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  localparam logic [AW-1:0]             ADR_ZERO  = {AW{1'b0}};
  localparam logic [REGISTER_COUNT-1:0] MASK_ZERO = {REGISTER_COUNT{1'b0}};
  // x0 is hard-wired, so its scoreboard bit is always masked off.
  localparam logic [REGISTER_COUNT-1:0] MASK_NO_X0 = ~{{(REGISTER_COUNT-1){1'b0}}, 1'b1};

  // One-hot decode of a register address into a scoreboard mask.
  function automatic logic [REGISTER_COUNT-1:0] onehot(input logic [AW-1:0] adr);
    logic [REGISTER_COUNT-1:0] m;
    m      = {REGISTER_COUNT{1'b0}};
    m[adr] = 1'b1;
    return m;
  endfunction

  src_e                      r_last_grant;
  logic                      r_we;
  logic [AW-1:0]             r_adr;
  logic [WORD_SIZE-1:0]      r_data;
  logic [REGISTER_COUNT-1:0] r_pending;

  logic                      w_alu_grant;
  logic                      w_mem_grant;
  logic                      w_grant;
  logic [AW-1:0]             w_sel_rd;
  logic [WORD_SIZE-1:0]      w_sel_data;
  logic                      w_issue_fire;
  logic [REGISTER_COUNT-1:0] w_set_mask;
  logic [REGISTER_COUNT-1:0] w_clr_mask;
  logic [REGISTER_COUNT-1:0] w_pending_next;

  // Round-robin arbitration: a tie goes to whoever was not granted last; reset blocks all grants.
  always_comb begin
    w_alu_grant = 1'b0;
    w_mem_grant = 1'b0;
    if (reset) begin
      w_alu_grant = 1'b0;
      w_mem_grant = 1'b0;
    end else if (alu_valid && mem_valid) begin
      if (r_last_grant == SRC_MEM) begin
        w_alu_grant = 1'b1;
      end else begin
        w_mem_grant = 1'b1;
      end
    end else if (alu_valid) begin
      w_alu_grant = 1'b1;
    end else if (mem_valid) begin
      w_mem_grant = 1'b1;
    end else begin
      w_alu_grant = 1'b0;
      w_mem_grant = 1'b0;
    end
  end

  // Select the winning request's address and data for the write stage.
  always_comb begin
    w_grant    = w_alu_grant | w_mem_grant;
    w_sel_rd   = alu_rdAdr;
    w_sel_data = alu_data;
    if (w_mem_grant) begin
      w_sel_rd   = mem_rdAdr;
      w_sel_data = mem_data;
    end else begin
      w_sel_rd   = alu_rdAdr;
      w_sel_data = alu_data;
    end
  end

  // Registered write stage: a grant becomes a register-file write in the next cycle; x0 never writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_adr  <= ADR_ZERO;
      r_data <= {WORD_SIZE{1'b0}};
    end else if (w_grant) begin
      r_we   <= (w_sel_rd != ADR_ZERO);
      r_adr  <= w_sel_rd;
      r_data <= w_sel_data;
    end else begin
      r_we   <= 1'b0;
    end
  end

  // Round-robin pointer moves only when somebody is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= SRC_MEM;
    end else if (w_alu_grant) begin
      r_last_grant <= SRC_ALU;
    end else if (w_mem_grant) begin
      r_last_grant <= SRC_MEM;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  // Scoreboard next state: a commit clears its bit, an issue sets its bit, and set wins a same-edge collision.
  always_comb begin
    w_issue_fire   = issue_valid && issue_ready && (issue_rdAdr != ADR_ZERO);
    w_set_mask     = MASK_ZERO;
    w_clr_mask     = MASK_ZERO;
    if (w_issue_fire) begin
      w_set_mask = onehot(issue_rdAdr);
    end else begin
      w_set_mask = MASK_ZERO;
    end
    if (r_we) begin
      w_clr_mask = onehot(r_adr);
    end else begin
      w_clr_mask = MASK_ZERO;
    end
    w_pending_next = ((r_pending & ~w_clr_mask) | w_set_mask) & MASK_NO_X0;
  end

  // Pending-write scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= MASK_ZERO;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  // Decode-side hazard outputs, computed combinationally from the registered scoreboard.
  always_comb begin
    issue_ready = !r_pending[issue_rdAdr] || (issue_rdAdr == ADR_ZERO);
    Stall       = (r_pending[rs1Adr] && (rs1Adr != ADR_ZERO)) ||
                  (r_pending[rs2Adr] && (rs2Adr != ADR_ZERO));
  end

  assign alu_ready   = w_alu_grant;
  assign mem_ready   = w_mem_grant;
  assign WriteEnable = r_we;
  assign rd1Adr      = r_adr;
  assign Rd1         = r_data;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler. Expected writes are queued when
// a grant is predicted and are popped when WriteEnable is seen. A small
// scoreboard model predicts the readies, Stall and issue_ready.
module tb_regfile_write_scheduler;

  localparam int WS = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [WS-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic [AW-1:0] issue_rdAdr;
  logic          issue_ready;
  logic [AW-1:0] rs1Adr;
  logic [AW-1:0] rs2Adr;
  logic          Stall;
  logic          alu_valid;
  logic [AW-1:0] alu_rdAdr;
  logic [WS-1:0] alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_rdAdr;
  logic [WS-1:0] mem_data;
  logic          mem_ready;
  logic          WriteEnable;
  logic [AW-1:0] rd1Adr;
  logic [WS-1:0] Rd1;

  int n_total = 0;
  int n_pass  = 0;

  wr_t        q[$];
  logic       m_we;
  logic       m_last_mem;
  logic [31:0] m_pend;
  logic       obs_ag, obs_mg, obs_stall, obs_ir;

  regfile_write_scheduler #(.WORD_SIZE(WS), .REGISTER_COUNT(32)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rdAdr(issue_rdAdr), .issue_ready(issue_ready),
    .rs1Adr(rs1Adr), .rs2Adr(rs2Adr), .Stall(Stall),
    .alu_valid(alu_valid), .alu_rdAdr(alu_rdAdr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rdAdr(mem_rdAdr), .mem_data(mem_data), .mem_ready(mem_ready),
    .WriteEnable(WriteEnable), .rd1Adr(rd1Adr), .Rd1(Rd1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: check outputs at the falling edge against the model, then advance the model.
  task automatic step(input string tag);
    wr_t         e;
    logic        clr;
    logic [AW-1:0] clr_adr;
    logic        exp_ir, exp_st, ag, mg;
    @(negedge clk);
    chk({tag, ":we"}, {31'd0, WriteEnable}, {31'd0, m_we});
    clr     = 1'b0;
    clr_adr = 5'd0;
    if (m_we) begin
      if (q.size() == 0) begin
        n_total++;
        $error("FAIL %s:queue observed=empty expected=entry", tag);
      end else begin
        e = q.pop_front();
        chk({tag, ":adr"}, {27'd0, rd1Adr}, {27'd0, e.adr});
        chk({tag, ":data"}, Rd1, e.data);
        clr     = 1'b1;
        clr_adr = e.adr;
      end
    end
    exp_ir = !m_pend[issue_rdAdr] || (issue_rdAdr == 5'd0);
    exp_st = (m_pend[rs1Adr] && (rs1Adr != 5'd0)) || (m_pend[rs2Adr] && (rs2Adr != 5'd0));
    ag = !reset && alu_valid && (!mem_valid || m_last_mem);
    mg = !reset && mem_valid && (!alu_valid || !m_last_mem);
    chk({tag, ":issue_ready"}, {31'd0, issue_ready}, {31'd0, exp_ir});
    chk({tag, ":stall"}, {31'd0, Stall}, {31'd0, exp_st});
    chk({tag, ":alu_ready"}, {31'd0, alu_ready}, {31'd0, ag});
    chk({tag, ":mem_ready"}, {31'd0, mem_ready}, {31'd0, mg});
    obs_ag    = alu_ready;
    obs_mg    = mem_ready;
    obs_stall = Stall;
    obs_ir    = issue_ready;
    if (reset) begin
      m_we       = 1'b0;
      m_pend     = 32'd0;
      m_last_mem = 1'b1;
    end else begin
      m_we = 1'b0;
      if (ag && alu_rdAdr != 5'd0) begin
        e.adr = alu_rdAdr; e.data = alu_data; q.push_back(e); m_we = 1'b1;
      end
      if (mg && mem_rdAdr != 5'd0) begin
        e.adr = mem_rdAdr; e.data = mem_data; q.push_back(e); m_we = 1'b1;
      end
      if (clr) m_pend[clr_adr] = 1'b0;
      if (issue_valid && exp_ir && issue_rdAdr != 5'd0) m_pend[issue_rdAdr] = 1'b1;
      if (ag) m_last_mem = 1'b0;
      else if (mg) m_last_mem = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_rdAdr = 5'd0; rs1Adr = 5'd0; rs2Adr = 5'd0;
    alu_valid = 1'b0; alu_rdAdr = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rdAdr = 5'd0; mem_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_we = 1'b0; m_pend = 32'd0; m_last_mem = 1'b1;

    // Reset state
    chk("rst_adr", {27'd0, rd1Adr}, 32'd0);
    chk("rst_data", Rd1, 32'd0);
    step("rst");

    // Single ALU write
    alu_valid = 1'b1; alu_rdAdr = 5'd5; alu_data = 32'hDEADBEEF;
    step("t1_req");
    chk("t1_alu_ready", {31'd0, obs_ag}, 32'd1);
    alu_valid = 1'b0;
    step("t1_wr");
    step("t1_idle");

    // Load-only write moves the pointer back to MEM
    mem_valid = 1'b1; mem_rdAdr = 5'd2; mem_data = 32'h0000_2222;
    step("t2_pre");
    mem_valid = 1'b0;

    // Contention: grants alternate ALU, MEM, ALU, MEM
    alu_valid = 1'b1; alu_rdAdr = 5'd3; alu_data = 32'hA000_0000;
    mem_valid = 1'b1; mem_rdAdr = 5'd4; mem_data = 32'hB000_0000;
    for (int i = 0; i < 4; i++) begin
      step("t2_tie");
      chk("t2_alu_alt", {31'd0, obs_ag}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_mem_alt", {31'd0, obs_mg}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (obs_ag) alu_data = alu_data + 32'd1;
      if (obs_mg) mem_data = mem_data + 32'd1;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    step("t2_drain");
    step("t2_idle");

    // RAW stall and WAW block on rd 7
    issue_valid = 1'b1; issue_rdAdr = 5'd7;
    step("t3_issue");
    chk("t3_issue_ok", {31'd0, obs_ir}, 32'd1);
    issue_valid = 1'b0; rs1Adr = 5'd7;
    step("t3_stall");
    chk("t3_stall_on", {31'd0, obs_stall}, 32'd1);
    issue_valid = 1'b1;
    step("t3_waw");
    chk("t3_waw_block", {31'd0, obs_ir}, 32'd0);
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_rdAdr = 5'd7; mem_data = 32'h0000_0777;
    step("t3_grant");
    mem_valid = 1'b0;
    step("t3_commit");
    chk("t3_stall_commit", {31'd0, obs_stall}, 32'd1);
    step("t3_release");
    chk("t3_stall_off", {31'd0, obs_stall}, 32'd0);
    rs1Adr = 5'd0;

    // x0 write and issue
    alu_valid = 1'b1; alu_rdAdr = 5'd0; alu_data = 32'h1;
    step("t4_x0_req");
    chk("t4_x0_ready", {31'd0, obs_ag}, 32'd1);
    alu_valid = 1'b0;
    step("t4_x0_nowr");
    issue_valid = 1'b1; issue_rdAdr = 5'd0; rs1Adr = 5'd0;
    step("t4_x0_issue");
    chk("t4_x0_ir", {31'd0, obs_ir}, 32'd1);
    chk("t4_x0_stall", {31'd0, obs_stall}, 32'd0);
    issue_valid = 1'b0;

    // Same-edge issue and commit on rd 9: set wins
    alu_valid = 1'b1; alu_rdAdr = 5'd9; alu_data = 32'h0000_0999;
    step("t5_req");
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_rdAdr = 5'd9;
    step("t5_collide");
    issue_valid = 1'b0; rs2Adr = 5'd9;
    step("t5_check");
    chk("t5_set_wins", {31'd0, obs_stall}, 32'd1);

    // Mid-operation reset with pending bits and both requesters valid
    issue_valid = 1'b1; issue_rdAdr = 5'd10;
    step("t6_issue");
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rdAdr = 5'd12; alu_data = 32'hC0C0_0012;
    mem_valid = 1'b1; mem_rdAdr = 5'd13; mem_data = 32'hD0D0_0013;
    reset = 1'b1;
    step("t6_reset");
    chk("t6_alu_blocked", {31'd0, obs_ag}, 32'd0);
    chk("t6_mem_blocked", {31'd0, obs_mg}, 32'd0);
    reset = 1'b0; rs1Adr = 5'd10;
    step("t6_after");
    chk("t6_stall_clear", {31'd0, obs_stall}, 32'd0);
    chk("t6_alu_first", {31'd0, obs_ag}, 32'd1);
    alu_valid = 1'b0;
    step("t6_mem");
    mem_valid = 1'b0; rs1Adr = 5'd0; rs2Adr = 5'd0;
    step("t6_drain");
    step("t6_idle");

    chk("queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
